// File: rtl/ext_sram_ctrl_pkg.sv
// Shared types and defaults for the ExtRAM SRAM controller: FSM state
// encoding, wait-state defaults and the wait-counter width.
package ext_sram_ctrl_pkg;

  localparam int unsigned RD_WAIT_DEF = 1;
  localparam int unsigned WR_WAIT_DEF = 1;
  localparam int unsigned WAIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/ext_sram_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the SRAM
// controller (slave); member names match the controller's original ports.
interface ext_sram_ctrl_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [3:0]  req_wbe_n_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wbe_n_i, req_wdata_i,
           resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wbe_n_i, req_wdata_i,
           resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o
  );

endinterface

// File: rtl/ext_sram_ctrl.sv
// Responder for CPU load/store requests that runs each one on the async
// ExtRAM SRAM with setup/strobe/hold timing; all pin outputs are registered.
module ext_sram_ctrl
  import ext_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 20,
  parameter int unsigned RD_WAIT   = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT   = WR_WAIT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ext_sram_ctrl_if.slave       bus,
  input  logic [31:0]          sram_data_i,
  output logic [31:0]          sram_data_o,
  output logic                 sram_data_oe_o,
  output logic [ADDR_BITS-1:0] sram_addr_o,
  output logic [3:0]           sram_be_n_o,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o
);

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   data_oe_q, data_oe_d;
  logic [3:0]             be_n_q, be_n_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   cnt_zero;
  logic                   unused_addr;

  // Byte-offset bits and bits above the SRAM word address are don't-care.
  assign unused_addr = ^bus.req_addr_i;
  assign cnt_zero    = (cnt_q == '0);

  assign bus.req_ready_o  = rst_ni && (state_q == ST_IDLE);
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = rdata_q;

  assign sram_data_o    = data_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_addr_o    = addr_q;
  assign sram_be_n_o    = be_n_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;

  // Pin values are computed for the state being entered, so each registered
  // output is already correct during the first cycle of its state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    data_oe_d    = data_oe_q;
    be_n_d       = be_n_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          addr_d = bus.req_addr_i[ADDR_BITS+1:2];
          if (!bus.req_we_i) begin
            state_d = ST_READ;
            cnt_d   = WAIT_CNT_W'(RD_WAIT);
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            be_n_d  = 4'h0;
          end else if (bus.req_wbe_n_i != 4'hF) begin
            state_d   = ST_WR_SETUP;
            cnt_d     = '0;
            ce_n_d    = 1'b0;
            be_n_d    = bus.req_wbe_n_i;
            data_d    = bus.req_wdata_i;
            data_oe_d = 1'b1;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (cnt_zero) begin
          state_d      = ST_RESP;
          rdata_d      = sram_data_i;
          ce_n_d       = 1'b1;
          oe_n_d       = 1'b1;
          be_n_d       = 4'hF;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_WR_PULSE;
          cnt_d   = WAIT_CNT_W'(WR_WAIT);
          we_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
          cnt_d   = '0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        if (cnt_zero) begin
          state_d      = ST_RESP;
          ce_n_d       = 1'b1;
          be_n_d       = 4'hF;
          data_oe_d    = 1'b0;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready_i) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      data_oe_q    <= 1'b0;
      be_n_q       <= 4'hF;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      data_oe_q    <= data_oe_d;
      be_n_q       <= be_n_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Randomized self-checking bench for ext_sram_ctrl with a behavioural SRAM
// and a word-array reference memory plus latency/strobe-count expectations.
module tb_ext_sram_ctrl;
  import ext_sram_ctrl_pkg::*;

  localparam int unsigned ADDR_BITS = 20;
  localparam int unsigned RD_WAIT   = 1;
  localparam int unsigned WR_WAIT   = 1;

  logic                 clk;
  logic                 rst_ni;
  logic [31:0]          sram_data_i;
  logic [31:0]          sram_data_o;
  logic                 sram_data_oe_o;
  logic [ADDR_BITS-1:0] sram_addr_o;
  logic [3:0]           sram_be_n_o;
  logic                 sram_ce_n_o;
  logic                 sram_oe_n_o;
  logic                 sram_we_n_o;

  ext_sram_ctrl_if bus ();

  ext_sram_ctrl #(
    .ADDR_BITS (ADDR_BITS),
    .RD_WAIT   (RD_WAIT),
    .WR_WAIT   (WR_WAIT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .bus            (bus),
    .sram_data_i    (sram_data_i),
    .sram_data_o    (sram_data_o),
    .sram_data_oe_o (sram_data_oe_o),
    .sram_addr_o    (sram_addr_o),
    .sram_be_n_o    (sram_be_n_o),
    .sram_ce_n_o    (sram_ce_n_o),
    .sram_oe_n_o    (sram_oe_n_o),
    .sram_we_n_o    (sram_we_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] sram_mem [0:255];
  logic [31:0] ref_mem  [0:255];
  logic [31:0] last_rdata = '0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return i * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural asynchronous SRAM: reads while ce/oe low, byte writes while ce/we low.
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o) begin
      if (!sram_be_n_o[0]) sram_mem[sram_addr_o[7:0]][7:0]   <= sram_data_o[7:0];
      if (!sram_be_n_o[1]) sram_mem[sram_addr_o[7:0]][15:8]  <= sram_data_o[15:8];
      if (!sram_be_n_o[2]) sram_mem[sram_addr_o[7:0]][23:16] <= sram_data_o[23:16];
      if (!sram_be_n_o[3]) sram_mem[sram_addr_o[7:0]][31:24] <= sram_data_o[31:24];
    end
  end

  task automatic scramble_req();
    bus.req_we_i    = 1'($urandom);
    bus.req_addr_i  = $urandom;
    bus.req_wbe_n_i = 4'($urandom);
    bus.req_wdata_i = $urandom;
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge one cycle after the handshake.
  task automatic run_txn(input bit we, input int unsigned waddr, input logic [3:0] wbe_n,
                         input logic [31:0] wdata, input int unsigned stall);
    bit          noop = we && (wbe_n == 4'hF);
    int unsigned lat_exp = !we ? RD_WAIT + 2 : (noop ? 1 : WR_WAIT + 4);
    logic [31:0] rdata_exp = we ? last_rdata : ref_mem[waddr];
    int unsigned resp_cyc = 0, oe_cnt = 0, we_cnt = 0, ce_cnt = 0, doe_cnt = 0;
    int unsigned first_ce = 0, first_we = 0, bad_pins = 0, bad_stall = 0;

    check_eq("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = {10'($urandom), 20'(waddr), 2'($urandom)};
    bus.req_wbe_n_i = wbe_n;
    bus.req_wdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    scramble_req();
    for (int unsigned cyc = 1; cyc <= 40; cyc++) begin
      if (bus.resp_valid_o) begin
        resp_cyc = cyc;
        break;
      end
      if (!sram_ce_n_o) begin
        ce_cnt++;
        if (first_ce == 0) first_ce = cyc;
        if (sram_addr_o !== 20'(waddr)) bad_pins++;
      end
      if (!sram_oe_n_o) begin
        oe_cnt++;
        if (sram_be_n_o !== 4'h0) bad_pins++;
      end
      if (!sram_we_n_o) begin
        we_cnt++;
        if (first_we == 0) first_we = cyc;
        if (sram_be_n_o !== wbe_n || sram_data_o !== wdata) bad_pins++;
      end
      if (sram_data_oe_o) doe_cnt++;
      if (!sram_oe_n_o && sram_data_oe_o) bad_pins++;
      if (bus.req_ready_o) bad_pins++;
      @(negedge clk);
      scramble_req();
    end

    check_eq("resp_latency", resp_cyc, lat_exp);
    check_eq("ce_low_cycles", ce_cnt, noop ? 0 : (we ? WR_WAIT + 3 : RD_WAIT + 1));
    check_eq("oe_low_cycles", oe_cnt, we ? 0 : RD_WAIT + 1);
    check_eq("we_low_cycles", we_cnt, (we && !noop) ? WR_WAIT + 1 : 0);
    check_eq("data_oe_cycles", doe_cnt, (we && !noop) ? WR_WAIT + 3 : 0);
    check_eq("first_ce_cycle", first_ce, noop ? 0 : 1);
    check_eq("first_we_cycle", first_we, (we && !noop) ? 2 : 0);
    check_eq("pin_values", bad_pins, 0);
    check_eq("resp_rdata", bus.resp_rdata_o, rdata_exp);

    for (int unsigned s = 0; s < stall; s++) begin
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== rdata_exp ||
          bus.req_ready_o !== 1'b0 || sram_ce_n_o !== 1'b1) bad_stall++;
      @(negedge clk);
    end
    check_eq("resp_stall_stable", bad_stall, 0);
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check_eq("resp_valid_drop", 32'(bus.resp_valid_o), 32'd0);
    check_eq("req_ready_after_hs", 32'(bus.req_ready_o), 32'd1);

    last_rdata = rdata_exp;
    if (we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (!wbe_n[b]) ref_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
      check_eq("sram_contents", sram_mem[waddr], ref_mem[waddr]);
    end
  endtask

  initial begin
    logic [31:0] exp_word;
    bit          saw_pulse;

    for (int unsigned i = 0; i < 256; i++) begin
      sram_mem[i] = init_word(i);
      ref_mem[i]  = init_word(i);
    end
    rst_ni           = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b0;
    scramble_req();
    repeat (3) @(negedge clk);

    check_eq("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check_eq("rst_strobes", {29'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'd7);
    check_eq("rst_be_n", 32'(sram_be_n_o), 32'hF);
    check_eq("rst_addr", 32'(sram_addr_o), 32'd0);
    check_eq("rst_data_o", sram_data_o, 32'd0);
    check_eq("rst_data_oe", 32'(sram_data_oe_o), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check_eq("rst_rdata", bus.resp_rdata_o, 32'd0);

    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(bus.req_ready_o), 32'd1);
      check_eq("idle_strobes", {29'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'd7);
    end

    sram_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4]  = 32'hDEAD_BEEF;
    run_txn(1'b0, 4, 4'h0, 32'h0, 0);
    check_eq("dir_load_data", bus.resp_rdata_o, 32'hDEAD_BEEF);

    exp_word = init_word(8);
    exp_word[15:0] = 16'h5678;
    run_txn(1'b1, 8, 4'b1100, 32'h1234_5678, 0);
    check_eq("dir_store_bytes", sram_mem[8], exp_word);

    run_txn(1'b1, 12, 4'hF, 32'hCAFE_F00D, 0);
    run_txn(1'b0, 12, 4'h0, 32'h0, 4);
    run_txn(1'b0, 8, 4'h0, 32'h0, 0);

    for (int unsigned t = 0; t < 40; t++)
      run_txn(1'($urandom), $urandom_range(0, 63), (t % 9 == 0) ? 4'hF : 4'($urandom),
              $urandom, $urandom_range(0, 3));

    // Store to a word that is never read back, interrupted by reset mid-pulse.
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 32'(100 << 2);
    bus.req_wbe_n_i = 4'h0;
    bus.req_wdata_i = 32'hA5A5_5A5A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    saw_pulse = 1'b0;
    for (int unsigned c = 0; c < 10 && !saw_pulse; c++) begin
      if (!sram_we_n_o) saw_pulse = 1'b1;
      else @(negedge clk);
    end
    check_eq("reset_test_pulse_seen", 32'(saw_pulse), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_we_n", 32'(sram_we_n_o), 32'd1);
    check_eq("midrst_data_oe", 32'(sram_data_oe_o), 32'd0);
    check_eq("midrst_ce_n", 32'(sram_ce_n_o), 32'd1);
    check_eq("midrst_req_ready", 32'(bus.req_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    last_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("postrst_no_resp", 32'(bus.resp_valid_o), 32'd0);
      check_eq("postrst_ready", 32'(bus.req_ready_o), 32'd1);
    end
    run_txn(1'b0, 4, 4'h0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
